p2s_stream: RTL

Parametrised parallel-to-serial converter with valid/ready handshakes on both sides. Accepts a DATA_W-bit word, shifts it out one bit per cycle in a configurable bit order, and marks the first and last bit of each word. Back-to-back words stream with no idle cycle between them. A serial-side ready allows the downstream sink to stall the shifter. It replaces the fixed 4-bit converter in the digital_circuit benchmark set.

---
 rtl/p2s_pkg.sv | 17 +
 rtl/p2s_shreg.sv | 52 +++++
 rtl/p2s_stream.sv | 108 ++++++++++
 3 files changed

// File: rtl/p2s_pkg.sv
// p2s_pkg: shared definitions for the parallel-to-serial stream converter.
//   p2s_state_e : converter state (IDLE = no word held, SHIFT = word held)
//   p2s_cnt_w() : width of the bit counter for a given word width
package p2s_pkg;

  typedef enum logic {
    P2S_IDLE  = 1'b0,
    P2S_SHIFT = 1'b1
  } p2s_state_e;

  // Width of a counter that indexes 0..data_w-1. It is never narrower than
  // one bit, so a 2-bit word still gets a usable counter.
  function automatic int p2s_cnt_w(input int data_w);
    return (data_w > 2) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/p2s_shreg.sv
// p2s_shreg: load/shift register for the parallel-to-serial converter.
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset (clears the register)
//   load     in   capture din (has priority over shift)
//   shift    in   move one position toward the output end
//   din      in   parallel word
//   out_bit  out  current output-end bit (bit DATA_W-1 or bit 0)
module p2s_shreg #(
  parameter int DATA_W    = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              out_bit
);

  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;
  logic [DATA_W-1:0] sr_shifted;

  // The output end is fixed by the bit order; the vacated end fills with 0.
  generate
    if (MSB_FIRST) begin : g_msb
      assign sr_shifted = {sr_q[DATA_W-2:0], 1'b0};
      assign out_bit    = sr_q[DATA_W-1];
    end else begin : g_lsb
      assign sr_shifted = {1'b0, sr_q[DATA_W-1:1]};
      assign out_bit    = sr_q[0];
    end
  endgenerate

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = sr_shifted;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/p2s_stream.sv
// p2s_stream: parallel-to-serial converter with valid/ready on both sides.
// A DATA_W-bit word is accepted on din and shifted out one bit per consumed
// cycle, in MSB-first or LSB-first order. The last bit of a word and the
// first bit of the next can be handed over on the same edge, so a steady
// stream of words produces a gap-free serial stream.
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   din         in   parallel word (sampled only on the accept edge)
//   din_valid   in   din is valid
//   din_ready   out  word accepted on an edge with din_valid && din_ready
//   dout        out  serial bit (0 when idle)
//   dout_valid  out  dout holds a valid bit
//   dout_first  out  dout is the first bit of a word
//   dout_last   out  dout is the last bit of a word
//   ser_ready   in   sink consumes dout on an edge with dout_valid && ser_ready
module p2s_stream
  import p2s_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              dout_first,
  output logic              dout_last,
  input  logic              ser_ready
);

  localparam int              CNT_W    = p2s_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  p2s_state_e       state_q;
  p2s_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic accept;
  logic consume;
  logic load;
  logic shift;
  logic out_bit;
  logic at_last;

  assign at_last = (cnt_q == CNT_LAST);

  // A new word fits either into an empty converter or into the slot being
  // freed by the consume of the current word's last bit. Holding ready low
  // during reset keeps a word from being "accepted" and then discarded.
  assign din_ready = rst && ((state_q == P2S_IDLE) || (ser_ready && at_last));
  assign accept    = din_valid && din_ready;
  assign consume   = (state_q == P2S_SHIFT) && ser_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    if (accept) begin
      // Covers both the idle load and the streaming reload on the last bit.
      state_d = P2S_SHIFT;
      cnt_d   = '0;
      load    = 1'b1;
    end else if (consume) begin
      if (!at_last) begin
        cnt_d = cnt_q + CNT_W'(1);
        shift = 1'b1;
      end else begin
        state_d = P2S_IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= P2S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  p2s_shreg #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (shift),
    .din    (din),
    .out_bit(out_bit)
  );

  // Outputs decode registered state only. The register keeps stale bits
  // after the word drains, so dout is gated by the state.
  assign dout_valid = (state_q == P2S_SHIFT);
  assign dout       = dout_valid && out_bit;
  assign dout_first = dout_valid && (cnt_q == '0);
  assign dout_last  = dout_valid && at_last;

endmodule
